invaders_video_fetch: RTL and testbench
=======================================

INVADERS_VIDEO_FETCH -- requirements
Module: invaders_video_fetch

Interface
REQ-001 SHALL have parameter H_TOTAL, default 320, pixels per line.
REQ-002 SHALL have parameter H_ACTIVE, default 256, visible pixels per line (multiple of 8).
REQ-003 SHALL have parameter V_TOTAL, default 262, lines per frame.
REQ-004 SHALL have parameter V_ACTIVE, default 224, visible lines per frame.
REQ-005 SHALL have parameter VRAM_BASE, default 13'h0400, video RAM byte offset within the 13-bit RAM address space.
REQ-006 SHALL have port Clock  in  1  system clock; the only clock.
REQ-007 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port ce_pix  in  1  pixel enable; asserted at most once every 3 Clock cycles.
REQ-009 SHALL have port vid_addr  out  13  video RAM read address.
REQ-010 SHALL have port vid_rd  out  1  one-cycle read strobe.
REQ-011 SHALL have port vid_data  in  8  RAM read data, valid 1 Clock after vid_rd.
REQ-012 SHALL have port color_prom_addr  out  11  colour PROM address.
REQ-013 SHALL have port color_prom_out  in  8  colour PROM data, valid 1 Clock after the address changes.
REQ-014 SHALL have ports pixel  out  1 and pix_color  out  3, the current mono pixel and its colour.
REQ-015 SHALL have ports hcount  out  9 and vcount  out  9, the raster position.
REQ-016 SHALL have ports hblank, vblank, hsync, vsync  out  1 each, active-high.

Function
REQ-017 SHALL change counters, pixel and colour state only on Clock edges with ce_pix=1.
REQ-018 SHALL increment hcount per ce_pix, wrapping H_TOTAL-1 -> 0, and SHALL increment vcount on that wrap, wrapping V_TOTAL-1 -> 0.
REQ-019 SHALL drive hblank=(hcount>=H_ACTIVE), vblank=(vcount>=V_ACTIVE), hsync=(272<=hcount<=303), vsync=(236<=vcount<=239), all registered in step with the counters.
REQ-020 SHALL, on ce_pix with hcount[2:0]=6 and hcount<H_ACTIVE-8 and vcount<V_ACTIVE, fetch byte (hcount[8:3]+1) of line vcount.
REQ-021 SHALL, on ce_pix with hcount=H_TOTAL-2, fetch byte 0 of the next line (line 0 when vcount=V_TOTAL-1), but only if that line is <V_ACTIVE.
REQ-022 SHALL form the fetch address as VRAM_BASE + line*32 + byte, truncated to 13 bits.
REQ-023 SHALL, for each fetch, pulse vid_rd for exactly one Clock, with vid_addr and color_prom_addr={vid_addr[12:7],vid_addr[4:0]} valid from that cycle and held until the next fetch.
REQ-024 SHALL capture vid_data and color_prom_out[2:0] into a fetch latch on the Clock after vid_rd.
REQ-025 SHALL never assert vid_rd outside REQ-020/REQ-021 events, giving exactly V_ACTIVE*H_ACTIVE/8 (7168 by default) strobes per frame.
REQ-026 SHALL, on the ce_pix edge where hcount becomes 8k inside the active area, load the shift register and colour register from the fetch latch, so that pixel=byte bit 0 in that same cycle.
REQ-027 SHALL shift right on each subsequent ce_pix, giving pixel=byte bit n at hcount=8k+n (LSB first).
REQ-028 SHALL drive pixel=0 and pix_color=0 whenever hblank or vblank is asserted.
REQ-029 SHALL, when ce_pix is held low, hold all outputs and issue no vid_rd.

Reset
REQ-030 SHALL, with Reset=1 on a Clock edge, clear hcount, vcount, the shift register, the colour register, the fetch latch, vid_addr, color_prom_addr, vid_rd, pixel and pix_color to 0, and SHALL drive all sync/blank outputs from the cleared counters.
REQ-031 SHALL give Reset priority over ce_pix, including when asserted mid-line or mid-fetch; the pending latch capture is discarded.
REQ-032 SHALL, after reset, display group 0 of line 0 as blank (no prefetch occurred), with normal fetching from hcount=6 onward.

Verification
REQ-033 SHALL pass: Reset, then 320*262 ce_pix (1 per 3 clocks) -> hcount 319->0 with vcount+1; vcount 261->0; vblank first high at vcount=224.
REQ-034 SHALL pass: RAM model with 0x0400=0xA5 (line 0 byte 0) -> line 0 hcount 0..7 of the second frame gives pixel 1,0,1,0,0,1,0,1.
REQ-035 SHALL pass: fetch of line 5 byte 3 -> vid_addr=0x04A3 and color_prom_addr=0x123; PROM data 0x06 -> pix_color=6 at hcount 24..31.
REQ-036 SHALL pass: count vid_rd over one full frame -> exactly 7168, none during vcount 223 hcount 318 through vcount 260.
REQ-037 SHALL pass: Reset asserted at hcount=100, vcount=50 -> next cycle all outputs 0, counters 0, vid_rd=0.
REQ-038 SHALL pass: ce_pix low for 100 clocks mid-line -> outputs unchanged and no vid_rd during the stall.

Source files
------------

// File: rtl/invaders_video_fetch.sv
// Raster timing, VRAM byte prefetch and an LSB-first pixel shifter for the 1-bpp display.
// Each byte is fetched two pixels before it is needed, so one ce_pix gap covers the RAM latency.
module invaders_video_fetch #(
    parameter int          H_TOTAL   = 320,
    parameter int          H_ACTIVE  = 256,
    parameter int          V_TOTAL   = 262,
    parameter int          V_ACTIVE  = 224,
    parameter logic [12:0] VRAM_BASE = 13'h0400
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ce_pix,
    output logic [12:0] vid_addr,
    output logic        vid_rd,
    input  logic [7:0]  vid_data,
    output logic [10:0] color_prom_addr,
    input  logic [7:0]  color_prom_out,
    output logic        pixel,
    output logic [2:0]  pix_color,
    output logic [8:0]  hcount,
    output logic [8:0]  vcount,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync
);
    localparam int STAGES = 1;
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_PRE  = 9'(H_TOTAL - 2);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] H_FLIM = 9'(H_ACTIVE - 8);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] color;
    } fetch_t;

    logic [8:0]        h_nxt, v_nxt, next_line;
    logic              h_wrap, fetch_line, fetch_pre, fetch_go, load;
    logic [12:0]       fetch_a;
    fetch_t            latch;
    logic [7:0]        shift;
    logic [2:0]        color;
    // [0] is the read strobe, [1] marks the cycle the RAM/PROM data is on the bus
    logic [STAGES:0]   vld_pipe;
    logic              unused_prom;

    function automatic logic [12:0] fetch_addr(input logic [8:0] line, input logic [5:0] byte_idx);
        return VRAM_BASE + 13'({line, 5'b00000}) + {7'b0, byte_idx};
    endfunction

    always_comb begin
        h_wrap     = (hcount == H_LAST);
        h_nxt      = h_wrap ? 9'd0 : hcount + 9'd1;
        next_line  = (vcount == V_LAST) ? 9'd0 : vcount + 9'd1;
        v_nxt      = h_wrap ? next_line : vcount;
        fetch_line = (hcount[2:0] == 3'd6) && (hcount < H_FLIM) && (vcount < V_ACT);
        fetch_pre  = (hcount == H_PRE) && (next_line < V_ACT);
        fetch_go   = ce_pix && (fetch_line || fetch_pre);
        fetch_a    = fetch_pre ? fetch_addr(next_line, 6'd0)
                               : fetch_addr(vcount, hcount[8:3] + 6'd1);
        load       = (h_nxt[2:0] == 3'd0) && (h_nxt < H_ACT) && (v_nxt < V_ACT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hcount          <= '0;
            vcount          <= '0;
            hblank          <= (H_ACT == 9'd0);
            vblank          <= (V_ACT == 9'd0);
            hsync           <= 1'b0;
            vsync           <= 1'b0;
            vld_pipe        <= '0;
            latch           <= '0;
            vid_addr        <= '0;
            color_prom_addr <= '0;
            shift           <= '0;
            color           <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], fetch_go};
            if (vld_pipe[STAGES])
                latch <= '{data: vid_data, color: color_prom_out[2:0]};
            if (ce_pix) begin
                hcount <= h_nxt;
                vcount <= v_nxt;
                hblank <= (h_nxt >= H_ACT);
                vblank <= (v_nxt >= V_ACT);
                hsync  <= (h_nxt >= 9'd272) && (h_nxt <= 9'd303);
                vsync  <= (v_nxt >= 9'd236) && (v_nxt <= 9'd239);
                if (fetch_go) begin
                    vid_addr        <= fetch_a;
                    color_prom_addr <= {fetch_a[12:7], fetch_a[4:0]};
                end
                if (load) begin
                    shift <= latch.data;
                    color <= latch.color;
                end else begin
                    shift <= {1'b0, shift[7:1]};
                end
            end
        end
    end

    assign vid_rd      = vld_pipe[0];
    assign pixel       = ~hblank & ~vblank & shift[0];
    assign pix_color   = (hblank | vblank) ? 3'd0 : color;
    assign unused_prom = ^color_prom_out[7:3];

endmodule

// File: tb/tb_invaders_video_fetch.sv
// Randomised ce_pix stimulus against a per-pixel reference model, on two raster geometries.
module tb_invaders_video_fetch;
    localparam int N = 2;
    localparam int HT[N] = '{320, 16};
    localparam int HA[N] = '{64, 8};
    localparam int VT[N] = '{12, 262};
    localparam int VA[N] = '{8, 224};

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       hb, vb, hs, vs, pix;
        logic [2:0] col;
    } st_t;

    logic Clock = 1'b0, Reset = 1'b1, ce_pix = 1'b0;
    logic [N-1:0][12:0] vid_addr;
    logic [N-1:0]       vid_rd;
    logic [N-1:0][7:0]  vid_data;
    logic [N-1:0][10:0] color_prom_addr;
    logic [N-1:0][7:0]  color_prom_out;
    logic [N-1:0]       pixel, hblank, vblank, hsync, vsync;
    logic [N-1:0][2:0]  pix_color;
    logic [N-1:0][8:0]  hcount, vcount;

    logic [7:0] mem  [8192];
    logic [7:0] prom [2048];
    int checks = 0, errors = 0;

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        invaders_video_fetch #(
            .H_TOTAL(HT[g]), .H_ACTIVE(HA[g]), .V_TOTAL(VT[g]), .V_ACTIVE(VA[g]),
            .VRAM_BASE(13'h0400)
        ) u_dut (
            .Clock(Clock), .Reset(Reset), .ce_pix(ce_pix),
            .vid_addr(vid_addr[g]), .vid_rd(vid_rd[g]), .vid_data(vid_data[g]),
            .color_prom_addr(color_prom_addr[g]), .color_prom_out(color_prom_out[g]),
            .pixel(pixel[g]), .pix_color(pix_color[g]),
            .hcount(hcount[g]), .vcount(vcount[g]),
            .hblank(hblank[g]), .vblank(vblank[g]), .hsync(hsync[g]), .vsync(vsync[g])
        );
    end

    // RAM: data one clock after the strobe; PROM: data one clock after the address
    always @(posedge Clock) begin
        for (int i = 0; i < N; i++) begin
            if (vid_rd[i]) vid_data[i] <= mem[vid_addr[i]];
            color_prom_out[i] <= prom[color_prom_addr[i]];
        end
    end

    // ---------------- reference model ----------------
    int   mh[N], mv[N];
    bit   fresh[N];
    st_t  exp_q[N][$];
    logic [12:0] fq[N][$];

    function automatic logic [12:0] faddr(input int line, input int b);
        int t;
        t = 'h400 + line * 32 + b;
        return t[12:0];
    endfunction

    function automatic logic [10:0] paddr(input logic [12:0] a);
        return {a[12:7], a[4:0]};
    endfunction

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int h, v, nl;
            st_t e;
            logic [12:0] a;
            logic [7:0] d;
            h = mh[i]; v = mv[i]; nl = (v + 1) % VT[i];
            if (h % 8 == 6 && h < HA[i] - 8 && v < VA[i]) fq[i].push_back(faddr(v, h / 8 + 1));
            if (h == HT[i] - 2 && nl < VA[i]) fq[i].push_back(faddr(nl, 0));
            h = h + 1;
            if (h == HT[i]) begin h = 0; v = nl; fresh[i] = 1'b0; end
            mh[i] = h; mv[i] = v;
            e = '0;
            e.h = 9'(h); e.v = 9'(v);
            e.hb = (h >= HA[i]); e.vb = (v >= VA[i]);
            e.hs = (h >= 272 && h <= 303); e.vs = (v >= 236 && v <= 239);
            // group 0 of the first line after reset was never prefetched
            if (!e.hb && !e.vb && !(fresh[i] && h < 8)) begin
                a = faddr(v, h / 8);
                d = mem[a];
                e.pix = d[h % 8];
                e.col = prom[paddr(a)][2:0];
            end
            exp_q[i].push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    logic ce_q = 1'b0, rst_q = 1'b0;
    bit   armed = 1'b0;
    st_t  last[N];
    int   rd_cnt[N];

    always @(posedge Clock) begin
        ce_q  <= ce_pix && !Reset;
        rst_q <= Reset;
    end

    always @(negedge Clock) begin
        if (rst_q) armed = 1'b1;
        if (armed) begin
            for (int i = 0; i < N; i++) begin
                st_t cur, e;
                logic [12:0] a;
                cur = '{hcount[i], vcount[i], hblank[i], vblank[i], hsync[i], vsync[i], pixel[i], pix_color[i]};
                if (vid_rd[i]) begin
                    rd_cnt[i]++;
                    checks++;
                    if (!ce_q || fq[i].size() == 0) begin
                        errors++;
                        $display("FAIL stray_rd inst %0d: vid_rd at addr %h, expected no read", i, vid_addr[i]);
                    end else begin
                        a = fq[i].pop_front();
                        if (vid_addr[i] !== a || color_prom_addr[i] !== paddr(a)) begin
                            errors++;
                            $display("FAIL fetch_addr inst %0d: got %h/%h expected %h/%h",
                                     i, vid_addr[i], color_prom_addr[i], a, paddr(a));
                        end
                    end
                end
                if (rst_q) begin
                    checks++;
                    if (cur !== '0 || vid_addr[i] !== '0 || color_prom_addr[i] !== '0 || vid_rd[i] !== 1'b0
                        || exp_q[i].size() != 0 || fq[i].size() != 0) begin
                        errors++;
                        $display("FAIL reset_state inst %0d: got %h addr %h prom %h rd %b pend %0d/%0d expected all 0",
                                 i, cur, vid_addr[i], color_prom_addr[i], vid_rd[i], exp_q[i].size(), fq[i].size());
                    end
                    exp_q[i].delete(); fq[i].delete();
                    last[i] = '0; rd_cnt[i] = 0;
                end else if (ce_q) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL no_expect inst %0d: got %h with empty scoreboard", i, cur);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL raster inst %0d: got %h expected %h", i, cur, e);
                        end
                        last[i] = e;
                        if (e.h == 0 && e.v == 0) begin
                            checks++;
                            if (rd_cnt[i] != VA[i] * HA[i] / 8) begin
                                errors++;
                                $display("FAIL frame_reads inst %0d: got %0d expected %0d", i, rd_cnt[i], VA[i] * HA[i] / 8);
                            end
                            rd_cnt[i] = 0;
                        end
                    end
                end else begin
                    checks++;
                    if (cur !== last[i]) begin
                        errors++;
                        $display("FAIL hold inst %0d: got %h expected %h", i, cur, last[i]);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge Clock); #1; end
    endtask

    task automatic do_ce(input int gap);
        model_step();
        ce_pix = 1'b1;
        @(posedge Clock); #1 ce_pix = 1'b0;
        idle(gap - 1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock); #1 Reset = 1'b0;
        for (int i = 0; i < N; i++) begin mh[i] = 0; mv[i] = 0; fresh[i] = 1'b1; end
        idle(2);
    endtask

    initial begin
        int tries;
        for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 2048; a++) prom[a] = 8'($urandom);
        mem[13'h0400] = 8'hA5;
        prom[11'h123] = 8'h06;
        idle(3);
        do_reset();

        for (int n = 0; n < 5000; n++) begin
            do_ce(3 + int'($urandom_range(0, 1)));
            if (n == 2000) idle(100);
        end

        // land a reset on the clock right after a mid-line fetch strobe
        tries = 0;
        while (!(mh[0] % 8 == 6 && mh[0] < HA[0] - 8 && mv[0] < VA[0]) && tries < 2000) begin
            do_ce(3);
            tries++;
        end
        checks++;
        if (tries >= 2000) begin
            errors++;
            $display("FAIL seek_fetch: no fetch position after %0d pixels, expected < 2000", tries);
        end
        do_ce(1);
        do_reset();

        for (int n = 0; n < 9000; n++) begin
            do_ce(3 + int'($urandom_range(0, 1)));
            if (n == 4000) idle(100);
        end
        idle(4);

        for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_q[i].size() != 0 || fq[i].size() != 0) begin
                errors++;
                $display("FAIL drain inst %0d: pending %0d/%0d expected 0/0", i, exp_q[i].size(), fq[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
